// File: rtl/nibble_alu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : nibble_alu_seq
// Brief    : W-bit add/sub sequencer using one 4-bit slice, LSB nibble first,
//            with valid/ready handshakes on request and result sides.
//            Define NIBSEQ_PIPE_EN to allow a new accept on the handoff cycle.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_alu_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic         out_cf,
    output logic         out_zero,
    output logic         out_overflow,
    output logic         busy
);

    localparam int C_NIB = W / 4;
    localparam int C_KW  = (C_NIB > 1) ? $clog2(C_NIB) : 1;
    localparam logic [C_KW-1:0] C_K_LAST = C_KW'(C_NIB - 1);

    generate
        if ((W % 4) != 0 || W < 8) begin : g_bad_width
            $error("nibble_alu_seq: W must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [W-1:0]    a_q,       a_d;
    logic [W-1:0]    b_q,       b_d;
    logic            sel_q,     sel_d;
    logic            c_q,       c_d;
    logic [C_KW-1:0] k_q,       k_d;
    logic [W-1:0]    res_q,     res_d;
    logic [W-1:0]    out_res_q, out_res_d;
    logic            out_cf_q,  out_cf_d;
    logic            out_zero_q, out_zero_d;
    logic            out_ovf_q, out_ovf_d;

    logic            w_accept;
    logic            w_handoff;
    logic [3:0]      w_nib_a;
    logic [3:0]      w_nib_b;
    logic [4:0]      w_sum;
    logic [W-1:0]    w_res_next;
    logic            w_cin_msb;

    assign out_valid    = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign out_res      = out_res_q;
    assign out_cf       = out_cf_q;
    assign out_zero     = out_zero_q;
    assign out_overflow = out_ovf_q;

`ifdef NIBSEQ_PIPE_EN
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
`else
    assign in_ready = (state_q == S_IDLE);
`endif

    assign w_accept  = in_valid && in_ready;
    assign w_handoff = out_valid && out_ready;

    // Operands shift right each RUN cycle so the active nibble is always [3:0];
    // the result fills from the top and lands aligned after the last nibble.
    assign w_nib_a    = a_q[3:0];
    assign w_nib_b    = b_q[3:0] ^ {4{sel_q}};
    assign w_sum      = {1'b0, w_nib_a} + {1'b0, w_nib_b} + {4'd0, c_q};
    assign w_res_next = {w_sum[3:0], res_q[W-1:4]};
    assign w_cin_msb  = w_nib_a[3] ^ w_nib_b[3] ^ w_sum[3];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        c_d        = c_q;
        k_d        = k_q;
        res_d      = res_q;
        out_res_d  = out_res_q;
        out_cf_d   = out_cf_q;
        out_zero_d = out_zero_q;
        out_ovf_d  = out_ovf_q;

        case (state_q)
            S_RUN: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                res_d = w_res_next;
                c_d   = w_sum[4];
                if (k_q == C_K_LAST) begin
                    state_d    = S_DONE;
                    out_res_d  = w_res_next;
                    out_cf_d   = sel_q ? ~w_sum[4] : w_sum[4];
                    out_zero_d = (w_res_next == '0);
                    out_ovf_d  = w_cin_msb ^ w_sum[4];
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE: begin
                if (w_handoff) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept overrides the DONE->IDLE step when pipelined issue is enabled.
        if (w_accept) begin
            state_d = S_RUN;
            a_d     = in_a;
            b_d     = in_b;
            sel_d   = in_sel;
            c_d     = in_sel;
            k_d     = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= 1'b0;
            c_q        <= 1'b0;
            k_q        <= '0;
            res_q      <= '0;
            out_res_q  <= '0;
            out_cf_q   <= 1'b0;
            out_zero_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            c_q        <= c_d;
            k_q        <= k_d;
            res_q      <= res_d;
            out_res_q  <= out_res_d;
            out_cf_q   <= out_cf_d;
            out_zero_q <= out_zero_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_alu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nibble_alu_seq
// Brief    : Scoreboard bench for nibble_alu_seq at W=16 (directed) and W=8
//            (random), honouring NIBSEQ_PIPE_EN for issue-interval expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_alu_seq;

`ifdef NIBSEQ_PIPE_EN
    localparam int C_GAP = 5;
`else
    localparam int C_GAP = 6;
`endif

    typedef struct packed {
        logic [15:0] res;
        logic        cf;
        logic        z;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid16, in_ready16, in_sel16, out_valid16, out_ready16;
    logic        out_cf16, out_zero16, out_ovf16, busy16;
    logic [15:0] in_a16, in_b16, out_res16;

    logic        in_valid8, in_ready8, in_sel8, out_valid8, out_ready8;
    logic        out_cf8, out_zero8, out_ovf8, busy8;
    logic [7:0]  in_a8, in_b8, out_res8;

    nibble_alu_seq #(.W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_sel(in_sel16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_res(out_res16), .out_cf(out_cf16), .out_zero(out_zero16),
        .out_overflow(out_ovf16), .busy(busy16)
    );

    nibble_alu_seq #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_sel(in_sel8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_res(out_res8), .out_cf(out_cf8), .out_zero(out_zero8),
        .out_overflow(out_ovf8), .busy(busy8)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;
    int   pop16_cyc[$];
    logic done8 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic sel);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] mask;
        logic        sa, sb, sr;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        full = sel ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.res = full[15:0] & mask;
        if (sel) e.cf = (a < b);
        else     e.cf = (w == 16) ? full[16] : full[8];
        sa = a[w-1];
        sb = b[w-1];
        sr = e.res[w-1];
        e.ov = sel ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        e.z  = (e.res == 16'h0000);
        return e;
    endfunction

    // Handshakes seen at a negedge complete on the following posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete();
            q8.delete();
        end else begin
            if (in_valid16 && in_ready16) q16.push_back(model(16, in_a16, in_b16, in_sel16));
            if (out_valid16 && out_ready16) begin
                if (q16.size() == 0) check("sb16_spurious", 32'd1, 32'd0);
                else begin
                    e16 = q16.pop_front();
                    check("res16", {16'd0, out_res16}, {16'd0, e16.res});
                    check("cf16",  {31'd0, out_cf16},   {31'd0, e16.cf});
                    check("zero16", {31'd0, out_zero16}, {31'd0, e16.z});
                    check("ovf16", {31'd0, out_ovf16},  {31'd0, e16.ov});
                    pop16_cyc.push_back(cyc);
                end
            end
            if (in_valid8 && in_ready8) begin
                q8.push_back(model(8, {8'd0, in_a8}, {8'd0, in_b8}, in_sel8));
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) check("sb8_spurious", 32'd1, 32'd0);
                else begin
                    e8 = q8.pop_front();
                    check("res8",  {24'd0, out_res8},  {16'd0, e8.res});
                    check("cf8",   {31'd0, out_cf8},   {31'd0, e8.cf});
                    check("zero8", {31'd0, out_zero8}, {31'd0, e8.z});
                    check("ovf8",  {31'd0, out_ovf8},  {31'd0, e8.ov});
                end
            end
        end
    end

    task automatic wait_ready16();
        int t = 0;
        @(negedge clk);
        while (!in_ready16 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("tmo_in_ready16", 32'd0, 32'd1);
    endtask

    task automatic wait_ready8();
        int t = 0;
        @(negedge clk);
        while (!in_ready8 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("tmo_in_ready8", 32'd0, 32'd1);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic sel,
                          output int t_acc);
        in_a16 = a; in_b16 = b; in_sel16 = sel; in_valid16 = 1'b1;
        wait_ready16();
        @(posedge clk); #1;
        t_acc = cyc;
        in_valid16 = 1'b0;
    endtask

    task automatic wait_valid16(output int t_val);
        int t = 0;
        @(negedge clk);
        while (!out_valid16 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("tmo_out_valid16", 32'd0, 32'd1);
        t_val = cyc;
    endtask

    logic [15:0] da[7] = '{16'hFFFF, 16'h0003, 16'h0005, 16'h7FFF, 16'h8000, 16'h8000, 16'hA5C3};
    logic [15:0] db[7] = '{16'h0001, 16'h0005, 16'h0005, 16'h0001, 16'h0001, 16'h8000, 16'h5A3D};
    logic        ds[7] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
    logic [7:0]  ea[4] = '{8'hFF, 8'h00, 8'h7F, 8'h80};
    logic [7:0]  eb[4] = '{8'h01, 8'h01, 8'h01, 8'h01};
    logic        es[4] = '{1'b0,  1'b1,  1'b0,  1'b1};

    initial begin
        int ta, tv, t1, t2, w;
        logic [15:0] held;
        rst_n = 1'b0;
        in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_sel16 = 1'b0; out_ready16 = 1'b1;
        in_valid8  = 1'b0; in_a8  = '0; in_b8  = '0; in_sel8  = 1'b0; out_ready8  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid16}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready16},  32'd1);
        check("rst_busy",      {31'd0, busy16},      32'd0);
        check("rst_res",       {16'd0, out_res16},   32'd0);
        check("rst_flags",     {29'd0, out_cf16, out_zero16, out_ovf16}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            send16(da[i], db[i], ds[i], ta);
            wait_valid16(tv);
            check("latency16", tv - ta, 32'd4);
            @(posedge clk); #1;
        end

        // Stall the consumer and offer a competing request meanwhile.
        send16(16'h00F0, 16'h0F10, 1'b0, ta);
        out_ready16 = 1'b0;
        wait_valid16(tv);
        held = out_res16;
        check("hold_res_value", {16'd0, held}, 32'h1000);
        @(posedge clk); #1;
        in_a16 = 16'hAAAA; in_b16 = 16'h5555; in_sel16 = 1'b1; in_valid16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_res_stable", {16'd0, out_res16}, {16'd0, held});
            check("hold_valid",      {31'd0, out_valid16}, 32'd1);
            check("hold_in_ready",   {31'd0, in_ready16},  32'd0);
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        @(posedge clk); #1;
        check("post_hold_busy",  {31'd0, busy16},      32'd0);
        check("post_hold_valid", {31'd0, out_valid16}, 32'd0);

        // Reset while the slice is on nibble k=2.
        send16(16'h4321, 16'h1111, 1'b0, ta);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid",    {31'd0, out_valid16}, 32'd0);
        check("midrst_busy",     {31'd0, busy16},      32'd0);
        check("midrst_in_ready", {31'd0, in_ready16},  32'd1);
        check("midrst_res",      {16'd0, out_res16},   32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_spurious_valid", {31'd0, out_valid16}, 32'd0);
        end
        @(posedge clk); #1;
        send16(16'h1234, 16'h1111, 1'b0, ta);
        wait_valid16(tv);
        check("after_rst_res", {16'd0, out_res16}, 32'h2345);
        @(posedge clk); #1;

        // Back-to-back issue with the consumer always ready.
        pop16_cyc.delete();
        in_a16 = 16'h0101; in_b16 = 16'h0202; in_sel16 = 1'b0; in_valid16 = 1'b1;
        wait_ready16();
        @(posedge clk); #1;
        t1 = cyc;
        in_a16 = 16'h0303; in_b16 = 16'h0404;
        wait_ready16();
        @(posedge clk); #1;
        t2 = cyc;
        in_valid16 = 1'b0;
        check("issue_gap", t2 - t1, C_GAP);
        w = 0;
        while (pop16_cyc.size() < 2 && w < 30) begin @(posedge clk); w++; end
        if (pop16_cyc.size() < 2) check("tmo_result_gap", 32'd0, 32'd1);
        else                      check("result_gap", pop16_cyc[1] - pop16_cyc[0], C_GAP);
        @(posedge clk); #1;

        // W=8 random sweep with a randomly stalling consumer.
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    if (i < 4) begin
                        in_a8 = ea[i]; in_b8 = eb[i]; in_sel8 = es[i];
                    end else begin
                        in_a8 = 8'($urandom); in_b8 = 8'($urandom); in_sel8 = 1'($urandom);
                    end
                    in_valid8 = 1'b1;
                    wait_ready8();
                    @(posedge clk); #1;
                end
                in_valid8 = 1'b0;
                done8 = 1'b1;
            end
            begin
                while (!done8) begin
                    @(posedge clk); #1;
                    out_ready8 = ($urandom_range(0, 3) != 0);
                end
                out_ready8 = 1'b1;
            end
        join

        repeat (20) @(posedge clk);
        check("sb16_drained", q16.size(), 32'd0);
        check("sb8_drained",  q8.size(),  32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
